// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared state encoding, bundle bit indices and small helpers for the MEM stage.
`default_nettype none

package mem_stage_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;

  function automatic logic is_mem_op(input logic [1:0] mem_ctl);
    return mem_ctl[MEMREAD] | mem_ctl[MEMWRITE];
  endfunction

  // A combined read+write request is treated as a write, so only a pure read returns data.
  function automatic logic is_read(input logic [1:0] mem_ctl);
    return mem_ctl[MEMREAD] & ~mem_ctl[MEMWRITE];
  endfunction

  function automatic logic [1:0] kill_regwrite(input logic [1:0] wb);
    logic [1:0] r;
    r           = 2'b00;
    r[MEMTOREG] = wb[MEMTOREG];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM/WB output bundle register with asynchronous reset and load enable.
`default_nettype none

module mem_wb_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              valid_d,
  input  logic [1:0]        wb_d,
  input  logic [DATA_W-1:0] alu_d,
  input  logic [DATA_W-1:0] rdata_d,
  input  logic [4:0]        rd_d,
  input  logic              err_d,
  input  logic              mis_d,
  output logic              valid_q,
  output logic [1:0]        wb_q,
  output logic [DATA_W-1:0] alu_q,
  output logic [DATA_W-1:0] rdata_q,
  output logic [4:0]        rd_q,
  output logic              err_q,
  output logic              mis_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      wb_q    <= 2'b00;
      alu_q   <= '0;
      rdata_q <= '0;
      rd_q    <= 5'd0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else if (load) begin
      valid_q <= valid_d;
      wb_q    <= wb_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_stage.sv
// mem_access_stage: EX/MEM consumer doing the data-memory req/ack access and driving MEM/WB.
// Optional MEM_ALIGN_CHECK_EN rejects word-misaligned accesses without issuing a request.
`default_nettype none

module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [1:0]        WB,
  input  logic [1:0]        we,
  input  logic [DATA_W-1:0] ALU_out,
  input  logic [DATA_W-1:0] d,
  input  logic [4:0]        rdAddr,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_wr,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              valid_out,
  output logic [1:0]        WB_out,
  output logic [DATA_W-1:0] alu_out_q,
  output logic [DATA_W-1:0] rdata_q,
  output logic [4:0]        rdAddr_q,
  output logic              mem_err,
  output logic              misalign
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       wb_lat;
  logic [1:0]       we_lat;
  logic [4:0]       rd_lat;

  logic              mem_op, mis, accept, done_ack, done_to, load;
  logic              nxt_valid, nxt_err, nxt_mis;
  logic [1:0]        nxt_wb;
  logic [DATA_W-1:0] nxt_alu, nxt_rdata;
  logic [4:0]        nxt_rd;

  always_comb begin
    mem_op = valid_in & is_mem_op(we);
`ifdef MEM_ALIGN_CHECK_EN
    mis = mem_op & (ALU_out[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    accept   = (state == IDLE) & mem_op & ~mis;
    done_ack = (state == BUSY) & dmem_ack;
    // Ack on the last allowed cycle still completes normally.
    done_to  = (state == BUSY) & ~dmem_ack & (cnt == CNT_W'(TIMEOUT - 1));
    stall    = accept | (state == BUSY);
    load     = (state == IDLE) | done_ack | done_to;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wb_lat     <= 2'b00;
      we_lat     <= 2'b00;
      rd_lat     <= 5'd0;
      dmem_req   <= 1'b0;
      dmem_wr    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wb_lat     <= WB;
            we_lat     <= we;
            rd_lat     <= rdAddr;
            dmem_req   <= 1'b1;
            dmem_wr    <= we[MEMWRITE];
            dmem_addr  <= ALU_out;
            dmem_wdata <= d;
            cnt        <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (done_ack || done_to) begin
            dmem_req <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // dmem_addr doubles as the latched ALU result for the outgoing bundle.
  always_comb begin
    if (state == IDLE) begin
      nxt_valid = valid_in & ~accept;
      nxt_wb    = mis ? kill_regwrite(WB) : WB;
      nxt_alu   = ALU_out;
      nxt_rdata = '0;
      nxt_rd    = rdAddr;
      nxt_err   = 1'b0;
      nxt_mis   = mis;
    end else begin
      nxt_valid = 1'b1;
      nxt_wb    = done_to ? kill_regwrite(wb_lat) : wb_lat;
      nxt_alu   = dmem_addr;
      nxt_rdata = (done_ack && is_read(we_lat)) ? dmem_rdata : '0;
      nxt_rd    = rd_lat;
      nxt_err   = done_to;
      nxt_mis   = 1'b0;
    end
  end

  mem_wb_reg #(
    .DATA_W (DATA_W)
  ) u_mem_wb_reg (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .valid_d (nxt_valid),
    .wb_d    (nxt_wb),
    .alu_d   (nxt_alu),
    .rdata_d (nxt_rdata),
    .rd_d    (nxt_rd),
    .err_d   (nxt_err),
    .mis_d   (nxt_mis),
    .valid_q (valid_out),
    .wb_q    (WB_out),
    .alu_q   (alu_out_q),
    .rdata_q (rdata_q),
    .rd_q    (rdAddr_q),
    .err_q   (mem_err),
    .mis_q   (misalign)
  );

endmodule

`default_nettype wire
